// File: rtl/console_write_ctrl.sv
// -----------------------------------------------------------------------------
// console_write_ctrl
//
// Purpose:
//   Owns the CPU-side write port of the text video memory. Takes one byte at a
//   time from the CPU over a valid/ready handshake and keeps a text cursor.
//   Printable bytes and a small set of control codes become single-cycle video
//   memory writes. A form feed runs a hardware clear-screen sweep.
//
// Ports:
//   CLK_CPU            in   1   system clock, rising edge
//   resetn             in   1   asynchronous active-low reset
//   char_valid         in   1   a byte is offered on char_data
//   char_data          in   8   offered byte
//   char_ready         out  1   byte can be accepted this cycle (IDLE only)
//   video_write_enable out  1   one-cycle write strobe
//   video_write_addr   out  11  row*COLS+col (or the clear counter)
//   video_write_data   out  32  byte in [7:0], upper bits zero
//   cursor_col         out  6   cursor column 0..COLS-1
//   cursor_row         out  5   cursor row 0..ROWS-1
//   busy               out  1   high while writing or clearing
//
// Build option:
//   CONSOLE_CLEAR_ON_RESET_EN - when defined, reset lands in the clear state,
//   so the screen is blanked before char_ready first rises.
// -----------------------------------------------------------------------------
module console_write_ctrl #(
  parameter int unsigned COLS   = 50,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 11,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              CLK_CPU,
  input  logic              resetn,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              video_write_enable,
  output logic [ADDR_W-1:0] video_write_addr,
  output logic [31:0]       video_write_data,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [5:0]        LAST_COL = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  // The clear counter holds the next address to blank; reaching the cell
  // count means the last cell has already been strobed.
  localparam logic [ADDR_W-1:0] CLR_END  = ADDR_W'(COLS * ROWS);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;

`ifdef CONSOLE_CLEAR_ON_RESET_EN
  localparam logic [1:0] RST_STATE = S_CLEAR;
  localparam logic       RST_READY = 1'b0;
  localparam logic       RST_BUSY  = 1'b1;
`else
  localparam logic [1:0] RST_STATE = S_IDLE;
  localparam logic       RST_READY = 1'b1;
  localparam logic       RST_BUSY  = 1'b0;
`endif

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;
  logic              r_busy;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic [5:0]        r_col;
  logic [4:0]        r_row;

  logic              w_accept;
  logic              w_is_print;
  logic [ADDR_W-1:0] w_addr_cur;
  logic [ADDR_W-1:0] w_addr_bs;
  logic [4:0]        w_row_inc;

  assign w_accept   = char_valid && r_ready;
  assign w_is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign w_addr_cur = (ADDR_W'(r_row) * COLS_A) + ADDR_W'(r_col);
  // Only used when col > 0, so the decrement never underflows.
  assign w_addr_bs  = w_addr_cur - ADDR_W'(1);
  // No scrolling: the row simply wraps back to the top.
  assign w_row_inc  = (r_row == LAST_ROW) ? 5'd0 : (r_row + 5'd1);

  // Main FSM: handshake, cursor tracking, write strobe and clear sweep.
  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_ready <= RST_READY;
      r_busy  <= RST_BUSY;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= 8'h00;
      r_col   <= 6'd0;
      r_row   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we <= 1'b0;
          if (w_accept) begin
            if (w_is_print) begin
              r_addr  <= w_addr_cur;
              r_data  <= char_data;
              r_we    <= 1'b1;
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              if (r_col == LAST_COL) begin
                r_col <= 6'd0;
                r_row <= w_row_inc;
              end else begin
                r_col <= r_col + 6'd1;
              end
            end else begin
              case (char_data)
                C_LF: begin
                  r_col <= 6'd0;
                  r_row <= w_row_inc;
                end
                C_CR: begin
                  r_col <= 6'd0;
                end
                C_BS: begin
                  if (r_col != 6'd0) begin
                    r_col   <= r_col - 6'd1;
                    r_addr  <= w_addr_bs;
                    r_data  <= BLANK;
                    r_we    <= 1'b1;
                    r_state <= S_WRITE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                  end else begin
                    r_col <= r_col;
                  end
                end
                C_FF: begin
                  // First blank goes out on the entry edge so every CLEAR
                  // cycle carries a strobe; counter then points at cell 1.
                  r_state <= S_CLEAR;
                  r_addr  <= '0;
                  r_data  <= BLANK;
                  r_we    <= 1'b1;
                  r_cnt   <= ADDR_W'(1);
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                end
                default: begin
                  r_state <= S_IDLE;
                end
              endcase
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_WRITE: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end

        S_CLEAR: begin
          if (r_cnt == CLR_END) begin
            r_we    <= 1'b0;
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_col   <= 6'd0;
            r_row   <= 5'd0;
          end else begin
            r_we   <= 1'b1;
            r_addr <= r_cnt;
            r_data <= BLANK;
            r_cnt  <= r_cnt + ADDR_W'(1);
          end
        end

        default: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign char_ready         = r_ready;
  assign busy               = r_busy;
  assign video_write_enable = r_we;
  assign video_write_addr   = r_addr;
  assign video_write_data   = {24'h000000, r_data};
  assign cursor_col         = r_col;
  assign cursor_row         = r_row;

endmodule

// File: tb/tb_console_write_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for console_write_ctrl. A queue-based model predicts the
// outputs cycle by cycle; directed sequences add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_console_write_ctrl;

  localparam int COLS  = 50;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int BLANK = 32'h20;

`ifdef CONSOLE_CLEAR_ON_RESET_EN
  localparam logic EXP_RST_READY = 1'b0;
  localparam logic EXP_RST_BUSY  = 1'b1;
`else
  localparam logic EXP_RST_READY = 1'b1;
  localparam logic EXP_RST_BUSY  = 1'b0;
`endif

  logic        CLK_CPU;
  logic        resetn;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        video_write_enable;
  logic [10:0] video_write_addr;
  logic [31:0] video_write_data;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  console_write_ctrl dut (
    .CLK_CPU            (CLK_CPU),
    .resetn             (resetn),
    .char_valid         (char_valid),
    .char_data          (char_data),
    .char_ready         (char_ready),
    .video_write_enable (video_write_enable),
    .video_write_addr   (video_write_addr),
    .video_write_data   (video_write_data),
    .cursor_col         (cursor_col),
    .cursor_row         (cursor_row),
    .busy               (busy)
  );

  initial begin
    CLK_CPU = 1'b0;
    forever #5 CLK_CPU = ~CLK_CPU;
  end

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // ---------------- behavioural model ----------------
  // Pending strobes are a queue of (data<<16 | addr); the controller is busy
  // while that queue drains, then idles for one cycle's worth of turnaround.
  int   wq[$];
  logic m_ready, m_busy, m_we;
  int   m_addr, m_data, m_col, m_row;
  bit   m_clr_end;

  task automatic model_reset();
    m_col = 0; m_row = 0; m_we = 1'b0; m_addr = 0; m_data = 0;
    wq.delete();
`ifdef CONSOLE_CLEAR_ON_RESET_EN
    for (int i = 0; i < CELLS; i++) wq.push_back(BLANK * 65536 + i);
    m_ready = 1'b0; m_busy = 1'b1; m_clr_end = 1'b1;
`else
    m_ready = 1'b1; m_busy = 1'b0; m_clr_end = 1'b0;
`endif
  endtask

  task automatic pop_strobe();
    int e;
    e = wq.pop_front();
    m_we = 1'b1; m_addr = e % 65536; m_data = e / 65536;
  endtask

  task automatic model_step();
    int b;
    if (!resetn) begin
      model_reset();
    end else if (!m_ready) begin
      if (wq.size() > 0) begin
        pop_strobe();
      end else begin
        m_we = 1'b0; m_ready = 1'b1; m_busy = 1'b0;
        if (m_clr_end) begin m_col = 0; m_row = 0; m_clr_end = 1'b0; end
      end
    end else begin
      m_we = 1'b0;
      if (char_valid) begin
        b = int'(char_data);
        if (b >= 32 && b <= 126) begin
          wq.push_back(b * 65536 + m_row * COLS + m_col);
          m_col = m_col + 1;
          if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        end else if (b == 10) begin
          m_col = 0; m_row = (m_row + 1) % ROWS;
        end else if (b == 13) begin
          m_col = 0;
        end else if (b == 8 && m_col > 0) begin
          m_col = m_col - 1;
          wq.push_back(BLANK * 65536 + m_row * COLS + m_col);
        end else if (b == 12) begin
          for (int i = 0; i < CELLS; i++) wq.push_back(BLANK * 65536 + i);
          m_clr_end = 1'b1;
        end
        if (wq.size() > 0) begin
          pop_strobe();
          m_ready = 1'b0; m_busy = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK_CPU or negedge resetn);
      model_step();
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  int log_a[$];
  int log_d[$];

  initial begin
    forever begin
      @(negedge CLK_CPU);
      if (check_en) begin
        check("cyc_ready", char_ready, m_ready);
        check("cyc_busy", busy, m_busy);
        check("cyc_we", video_write_enable, m_we);
        check("cyc_col", cursor_col, m_col);
        check("cyc_row", cursor_row, m_row);
        if (m_we) begin
          check("cyc_addr", video_write_addr, m_addr);
          check("cyc_data", video_write_data, m_data);
        end
        if (video_write_enable) begin
          log_a.push_back(int'(video_write_addr));
          log_d.push_back(int'(video_write_data));
        end
      end
    end
  end

  function automatic int log_addr(input int i);
    return (i < log_a.size()) ? log_a[i] : -1;
  endfunction

  function automatic int log_data(input int i);
    return (i < log_d.size()) ? log_d[i] : -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_CPU);
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!char_ready && n < 4000) begin
      @(negedge CLK_CPU);
      n++;
    end
    if (n >= 4000) timeout_fail(nm);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK_CPU);
    wait_ready("send_ready");
    char_valid = 1'b1;
    char_data  = b;
    @(negedge CLK_CPU);
    char_valid = 1'b0;
    char_data  = 8'h00;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int low, bad, cnt, n;
    char_valid = 1'b0;
    char_data  = 8'h00;
    resetn     = 1'b1;
    #1 resetn  = 1'b0;
    #1 check_en = 1'b1;
    check("rst_ready", char_ready, EXP_RST_READY);
    check("rst_busy", busy, EXP_RST_BUSY);
    check("rst_we", video_write_enable, 1'b0);
    check("rst_addr", video_write_addr, 11'd0);
    check("rst_data", video_write_data, 32'h0);
    check("rst_col", cursor_col, 6'd0);
    check("rst_row", cursor_row, 5'd0);
    idle(2);
    resetn = 1'b1;

    // 'A' with valid held: one strobe, ready low for exactly one cycle
    @(negedge CLK_CPU);
    wait_ready("a_ready");
    char_valid = 1'b1;
    char_data  = 8'h41;
    @(posedge CLK_CPU); #1;
    check("a_we", video_write_enable, 1'b1);
    check("a_addr", video_write_addr, 11'd0);
    check("a_data", video_write_data, 32'h41);
    check("a_col", cursor_col, 6'd1);
    check("a_ready_low", char_ready, 1'b0);
    @(posedge CLK_CPU); #1;
    check("a_we_drop", video_write_enable, 1'b0);
    check("a_ready_back", char_ready, 1'b1);
    char_valid = 1'b0;
    send(8'h0D);
    idle(2);
    check("cr_col", cursor_col, 6'd0);

    // 50 printables fill row 0, then wrap to row 1
    clear_log();
    for (int i = 0; i < 50; i++) send(8'h41 + 8'(i % 26));
    idle(2);
    check("row_fill_count", log_a.size(), 50);
    bad = 0;
    for (int i = 0; i < 50; i++) if (log_addr(i) != i) bad++;
    check("row_fill_order", bad, 0);
    check("row_fill_col", cursor_col, 6'd0);
    check("row_fill_row", cursor_row, 5'd1);
    send(8'h2E);
    idle(2);
    check("byte51_addr", log_addr(50), 50);
    check("byte51_col", cursor_col, 6'd1);

    // FF with 'A' held behind it
    clear_log();
    @(negedge CLK_CPU);
    wait_ready("ff_ready");
    char_valid = 1'b1;
    char_data  = 8'h0C;
    @(negedge CLK_CPU);
    char_data = 8'h41;
    low = 0;
    while (!char_ready && low < 4000) begin
      low++;
      @(negedge CLK_CPU);
    end
    @(negedge CLK_CPU);
    char_valid = 1'b0;
    idle(2);
    check("ff_ready_low_cycles", low, 1500);
    check("ff_log_count", log_a.size(), 1501);
    bad = 0;
    for (int i = 0; i < 1500; i++) if (log_addr(i) != i || log_data(i) != 32'h20) bad++;
    check("ff_sweep", bad, 0);
    check("ff_a_addr", log_addr(1500), 0);
    check("ff_a_data", log_data(1500), 32'h41);
    check("ff_a_col", cursor_col, 6'd1);
    check("ff_a_row", cursor_row, 5'd0);

    // Bottom-right corner wrap
    send(8'h0D);
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 49; i++) send(8'h61);
    idle(2);
    check("corner_col", cursor_col, 6'd49);
    check("corner_row", cursor_row, 5'd29);
    clear_log();
    send(8'h5A);
    idle(2);
    check("corner_addr", log_addr(0), 1499);
    check("corner_data", log_data(0), 32'h5A);
    check("corner_wrap_col", cursor_col, 6'd0);
    check("corner_wrap_row", cursor_row, 5'd0);
    for (int i = 0; i < 29; i++) send(8'h0A);
    clear_log();
    send(8'h0A);
    idle(2);
    check("lf_wrap_row", cursor_row, 5'd0);
    check("lf_no_strobe", log_a.size(), 0);

    // Backspace
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 3; i++) send(8'h78);
    clear_log();
    send(8'h08);
    idle(2);
    check("bs_addr", log_addr(0), 102);
    check("bs_data", log_data(0), 32'h20);
    check("bs_col", cursor_col, 6'd2);
    check("bs_row", cursor_row, 5'd2);
    send(8'h0D);
    clear_log();
    send(8'h08);
    idle(1);
    check("bs0_ready", char_ready, 1'b1);
    idle(1);
    check("bs0_no_strobe", log_a.size(), 0);
    check("bs0_col", cursor_col, 6'd0);
    send(8'h01);
    idle(2);
    check("ign_no_strobe", log_a.size(), 0);
    check("ign_row", cursor_row, 5'd2);

    // Reset in the middle of a clear
    send(8'h0C);
    cnt = 0;
    n = 0;
    while (n < 2000) begin
      if (video_write_enable) cnt++;
      if (cnt == 700) break;
      @(negedge CLK_CPU);
      n++;
    end
    if (cnt != 700) timeout_fail("midclr_strobe700");
    #1 resetn = 1'b0;
    #1;
    check("midclr_we_drop", video_write_enable, 1'b0);
    check("midclr_col", cursor_col, 6'd0);
    check("midclr_row", cursor_row, 5'd0);
    check("midclr_busy", busy, EXP_RST_BUSY);
    clear_log();
    idle(2);
    resetn = 1'b1;
    @(negedge CLK_CPU);
`ifdef CONSOLE_CLEAR_ON_RESET_EN
    wait_ready("rst_clear_done");
    idle(1);
    check("rst_clear_count", log_a.size(), 1500);
    check("rst_clear_first", log_addr(0), 0);
    check("rst_clear_last", log_addr(1499), 1499);
`else
    check("post_rst_ready", char_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    idle(1);
    check("post_rst_no_strobe", log_a.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
